dmac_mc_regs: RTL
=================

Name: dmac_mc_regs

Overview:
Parametrised multi-channel successor to the SDMAC register block. It decodes CPU register cycles into NCH identical per-channel register windows. Each channel has a control register, a live transfer counter (WTC) that decrements per transferred word and raises terminal count, a latched interrupt status, and a FIFO flush handshake. It aggregates channel interrupts onto INT_O_ and generates the register-cycle termination REG_DSK_ with programmable wait states. It sits between the CPU bus FSM and the per-channel FIFO/DMA datapaths.

Parameters:
NCH, 2, number of DMA channels (1..4)
WTC_W, 24, transfer counter width in bits (1..32)
TERM_WS, 2, CLK cycles from access start to REG_DSK_ assertion (1..7)

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST_  in  1  reset, asynchronous, active-low
ADDR  in  8  CPU address; ADDR[6:5] channel, ADDR[4:2] register, ADDR[1:0] ignored
DMAC_  in  1  chip select, active-low
AS_  in  1  CPU address strobe, active-low
RW  in  1  1 = read, 0 = write
MID  in  32  write data
XFER_DONE  in  NCH  one-cycle pulse per word transferred, per channel
FIFOEMPTY  in  NCH  FIFO empty flags
FIFOFULL  in  NCH  FIFO full flags
STOPFLUSH  in  NCH  flush-complete acknowledge
REG_OD  out  32  read data
REG_DSK_  out  1  register cycle termination, active-low
INT_O_  out  1  aggregated interrupt, active-low
DMAENA  out  NCH  channel enabled
DMADIR  out  NCH  channel direction (1 = write to memory)
FLUSHFIFO  out  NCH  flush request
PRESET  out  1  peripheral reset, channel 0 CNTR bit 4

Behaviour:
- Access: ACC = ~DMAC_ & ~AS_. START is a one-cycle pulse on the first rising edge ACC is seen high; it re-arms only after ACC has been low for at least one cycle. Every write or strobe action fires on START only, so each bus cycle acts exactly once.
- Register map (ADDR[4:2]):
  - 0: WTC, read/write.
  - 1: CNTR, read/write, bits [4:0] = {PRESET, INTENA, DMADIR, rsvd, rsvd}.
  - 2: ST_DMA strobe.
  - 3: SP_DMA strobe.
  - 4: CLR_INT strobe.
  - 5: FLUSH strobe.
  - 6: ISTR, read-only.
  - 7: reserved; reads 0, writes ignored.
- Strobes fire on either RW value.
- Channel index >= NCH: reads 0, writes and strobes ignored, but the cycle is still terminated.
- REG_OD:
  - Combinational from the decoded register while ACC & RW; 0 otherwise.
  - WTC is zero-extended to 32 bits.
  - CNTR is {27'b0, CNTR[4:0]}.
  - ISTR is {28'b0, INTP, TC, FIFOFULL, FIFOEMPTY}, where FIFO bits are live and INTP = TC & INTENA.
- REG_DSK_:
  - Goes low exactly TERM_WS cycles after START; a cycle counter counts from START.
  - Stays low while ACC holds and returns high on the first edge after ACC falls.
  - If AS_ rises before TERM_WS cycles elapse, the cycle is aborted: REG_DSK_ never asserts and any action has already fired.
- WTC, per channel:
  - A write loads MID[WTC_W-1:0].
  - Otherwise, XFER_DONE while DMAENA and WTC != 0 decrements by 1.
  - Write wins over a simultaneous XFER_DONE.
  - A decrement from 1 to 0 sets TC and clears DMAENA on the same edge.
  - XFER_DONE at WTC = 0 does nothing: no wrap and no new TC.
- DMAENA:
  - Set by ST_DMA only when WTC != 0; ST_DMA with WTC = 0 sets TC immediately and leaves DMAENA at 0.
  - Cleared by SP_DMA or by terminal count.
  - SP_DMA wins over simultaneous events.
- TC: latched; cleared by CLR_INT. A simultaneous set and clear leaves TC = 1.
- INT_O_ = ~|(TC & INTENA) over all channels, registered, so one cycle of latency.
- FLUSHFIFO, per channel: set by the FLUSH strobe, cleared by STOPFLUSH. Set wins when both occur together.
- DMADIR = CNTR bit 2; PRESET = channel 0 CNTR bit 4.
- Reset values:
  - WTC = 0, CNTR = 0, TC = 0, DMAENA = 0, FLUSHFIFO = 0.
  - REG_DSK_ = 1, INT_O_ = 1, PRESET = 0, DMADIR = 0, REG_OD = 0.
- Reset asserted mid-cycle:
  - All state returns to reset values immediately.
  - START re-arms only after ACC has been seen low, so a cycle still in progress when reset releases is not re-executed.

Test Plan:
- Write WTC ch1 = 0x000003, CNTR ch1 = 0x08, ST_DMA ch1, then 3 XFER_DONE[1] pulses -> WTC reads 2, 1, 0. DMAENA[1] falls on the 3rd pulse, TC set, INT_O_ low one cycle later. ISTR ch1 reads 0xC | FIFO bits.
- CLR_INT ch1 on the same edge as a new terminal count -> TC stays 1. A second CLR_INT -> TC = 0, INT_O_ = 1.
- Each access with TERM_WS = 2 -> REG_DSK_ low exactly 2 cycles after START, high 1 cycle after AS_ rises. A write holding AS_ low for 10 cycles updates the register once.
- ST_DMA with WTC = 0 -> DMAENA stays 0, TC = 1. XFER_DONE at WTC = 0 -> WTC remains 0, with no wrap to 0xFFFFFF.
- Read ADDR = 0x60 with NCH = 2 -> REG_OD = 0 and REG_DSK_ still asserts. Write CNTR ch0 = 0x10 -> PRESET = 1, other channels unaffected.
- FLUSH ch0 with STOPFLUSH[0] high on the same edge -> FLUSHFIFO[0] = 1, cleared on the next STOPFLUSH. Assert RST_ mid-cycle -> all outputs at reset values, with no action on release while AS_ is still low.

Source files
------------

// File: rtl/dmac_mc_regs.sv
// Multi-channel DMA controller register block: decodes CPU register cycles into NCH channel windows.
// Latency: writes/strobes act on the START edge, REG_DSK_ asserts TERM_WS cycles later, INT_O_ lags TC by one cycle.
// Backpressure: none; the CPU cycle is held by REG_DSK_ until ACC drops; each bus cycle acts exactly once.
//
// Ports: CLK/RST_ (async active-low); CPU side ADDR, DMAC_, AS_, RW, MID -> REG_OD, REG_DSK_;
// per-channel datapath side XFER_DONE, FIFOEMPTY, FIFOFULL, STOPFLUSH -> DMAENA, DMADIR, FLUSHFIFO;
// INT_O_ aggregated interrupt; PRESET peripheral reset from channel 0 CNTR bit 4.
module dmac_mc_regs #(
    parameter int NCH     = 2,
    parameter int WTC_W   = 24,
    parameter int TERM_WS = 2
) (
    input  logic             CLK,
    input  logic             RST_,
    input  logic [7:0]       ADDR,
    input  logic             DMAC_,
    input  logic             AS_,
    input  logic             RW,
    input  logic [31:0]      MID,
    input  logic [NCH-1:0]   XFER_DONE,
    input  logic [NCH-1:0]   FIFOEMPTY,
    input  logic [NCH-1:0]   FIFOFULL,
    input  logic [NCH-1:0]   STOPFLUSH,
    output logic [31:0]      REG_OD,
    output logic             REG_DSK_,
    output logic             INT_O_,
    output logic [NCH-1:0]   DMAENA,
    output logic [NCH-1:0]   DMADIR,
    output logic [NCH-1:0]   FLUSHFIFO,
    output logic             PRESET
);

    localparam logic [2:0] TWS = 3'(TERM_WS);

    logic             acc;
    logic             armed;
    logic             start;
    logic [1:0]       ch;
    logic [2:0]       rsel;
    logic             ch_ok;
    logic [2:0]       cnt;
    logic             dsk_n;
    logic             int_n;

    logic [WTC_W-1:0] wtc [NCH];
    logic [4:0]       cntr [NCH];
    logic [NCH-1:0]   tc;
    logic [NCH-1:0]   dmaena_q;
    logic [NCH-1:0]   flush_q;

    logic [NCH-1:0]   intena;
    logic [NCH-1:0]   dir;
    logic [NCH-1:0]   wtc_wr;
    logic [NCH-1:0]   cntr_wr;
    logic [NCH-1:0]   st_stb;
    logic [NCH-1:0]   sp_stb;
    logic [NCH-1:0]   clr_stb;
    logic [NCH-1:0]   fl_stb;
    logic [NCH-1:0]   wtc_nz;
    logic [NCH-1:0]   dec;
    logic [NCH-1:0]   dec_tc;
    logic [NCH-1:0]   tc_set;
    logic [31:0]      rd;

    // ADDR[7], ADDR[1:0] and upper MID bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{ADDR[7], ADDR[1:0], MID};

    assign acc   = ~DMAC_ & ~AS_;
    // armed is cleared by reset, so a cycle still held across reset release never fires.
    assign start = acc & armed;
    assign ch    = ADDR[6:5];
    assign rsel  = ADDR[4:2];
    assign ch_ok = ({30'b0, ch} < 32'(NCH));

    always_comb begin
        intena  = '0;
        dir     = '0;
        wtc_wr  = '0;
        cntr_wr = '0;
        st_stb  = '0;
        sp_stb  = '0;
        clr_stb = '0;
        fl_stb  = '0;
        wtc_nz  = '0;
        dec     = '0;
        dec_tc  = '0;
        tc_set  = '0;
        for (int i = 0; i < NCH; i++) begin
            intena[i]  = cntr[i][3];
            dir[i]     = cntr[i][2];
            // Strobes fire for either RW value; register loads only on writes.
            wtc_wr[i]  = start & ch_ok & (ch == 2'(i)) & ~RW & (rsel == 3'd0);
            cntr_wr[i] = start & ch_ok & (ch == 2'(i)) & ~RW & (rsel == 3'd1);
            st_stb[i]  = start & ch_ok & (ch == 2'(i)) & (rsel == 3'd2);
            sp_stb[i]  = start & ch_ok & (ch == 2'(i)) & (rsel == 3'd3);
            clr_stb[i] = start & ch_ok & (ch == 2'(i)) & (rsel == 3'd4);
            fl_stb[i]  = start & ch_ok & (ch == 2'(i)) & (rsel == 3'd5);
            wtc_nz[i]  = (wtc[i] != '0);
            // A CPU write to WTC takes precedence over a word-done decrement.
            dec[i]     = ~wtc_wr[i] & XFER_DONE[i] & dmaena_q[i] & wtc_nz[i];
            dec_tc[i]  = dec[i] & (wtc[i] == WTC_W'(1));
            // Starting a channel with nothing to move is an immediate terminal count.
            tc_set[i]  = dec_tc[i] | (st_stb[i] & ~wtc_nz[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            for (int i = 0; i < NCH; i++) begin
                wtc[i]  <= '0;
                cntr[i] <= '0;
            end
            tc       <= '0;
            dmaena_q <= '0;
            flush_q  <= '0;
            armed    <= 1'b0;
            cnt      <= '0;
            dsk_n    <= 1'b1;
            int_n    <= 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wtc_wr[i])
                    wtc[i] <= MID[WTC_W-1:0];
                else if (dec[i])
                    wtc[i] <= wtc[i] - WTC_W'(1);

                if (cntr_wr[i])
                    cntr[i] <= MID[4:0];

                if (sp_stb[i])
                    dmaena_q[i] <= 1'b0;
                else if (dec_tc[i])
                    dmaena_q[i] <= 1'b0;
                else if (st_stb[i] && wtc_nz[i])
                    dmaena_q[i] <= 1'b1;

                if (tc_set[i])
                    tc[i] <= 1'b1;
                else if (clr_stb[i])
                    tc[i] <= 1'b0;

                if (fl_stb[i])
                    flush_q[i] <= 1'b1;
                else if (STOPFLUSH[i])
                    flush_q[i] <= 1'b0;
            end

            armed <= ~acc;
            int_n <= ~|(tc & intena);

            // cnt = number of edges since START (inclusive), saturating; 0 = no cycle in progress.
            if (!acc)
                cnt <= '0;
            else if (start)
                cnt <= 3'd1;
            else if (cnt != 3'd0 && cnt != 3'd7)
                cnt <= cnt + 3'd1;

            dsk_n <= ~(acc && cnt != 3'd0 && cnt >= TWS);
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_ok && ch == 2'(i)) begin
                case (rsel)
                    3'd0:    rd[WTC_W-1:0] = wtc[i];
                    3'd1:    rd[4:0]       = cntr[i];
                    3'd6:    rd[3:0]       = {tc[i] & intena[i], tc[i], FIFOFULL[i], FIFOEMPTY[i]};
                    default: rd            = '0;
                endcase
            end
        end
    end

    assign REG_OD    = (acc && RW && RST_) ? rd : 32'd0;
    assign REG_DSK_  = dsk_n;
    assign INT_O_    = int_n;
    assign DMAENA    = dmaena_q;
    assign DMADIR    = dir;
    assign FLUSHFIFO = flush_q;
    assign PRESET    = cntr[0][4];

endmodule
